rvc_asap_imem_loader: RTL and testbench

//  Upstream boot stage of the single-cycle core. Receives a byte stream (valid/ready),

---
 rtl/rvc_asap_pkg.sv | 36 +++
 rtl/rvc_asap_byte_packer.sv | 35 +++
 rtl/rvc_asap_imem_loader.sv | 158 +++++++++++++++
 tb/tb_rvc_asap_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap core and its I_MEM boot loader.
// This file also defines the common flop macros RVC_RST_MSFF and RVC_EN_MSFF.

`ifndef RVC_MSFF_MACROS
`define RVC_MSFF_MACROS
`define RVC_RST_MSFF(q, i, clk, rst, rst_val) \
  always_ff @(posedge clk or posedge rst) begin \
    if (rst) q <= rst_val; \
    else     q <= i; \
  end
`define RVC_EN_MSFF(q, i, clk, en) \
  always_ff @(posedge clk) begin \
    if (en) q <= i; \
  end
`endif

package rvc_asap_pkg;

  localparam int unsigned I_MEM_MSB  = 'hFFF;
  localparam int unsigned I_MEM_SIZE = I_MEM_MSB + 1;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } t_loader_state;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CSUM = 2'b10
  } t_loader_err;

endpackage

// File: rtl/rvc_asap_byte_packer.sv
// 8->32 little-endian packer: the first byte of each group lands in Word[7:0].
// WordValid pulses combinationally together with the 4th byte of each group.

module rvc_asap_byte_packer (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        Clr,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        WordValid,
  output logic [31:0] Word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;

  // Byte position within the current word; restarts on Clr.
  always_comb begin
    idx_d = idx_q;
    if (Clr)          idx_d = 2'd0;
    else if (InValid) idx_d = idx_q + 2'd1;
  end

  // Holds the three low bytes of the current word.
  assign sh_d = {InData, sh_q[23:8]};

  // Byte position flop.
  `RVC_RST_MSFF(idx_q, idx_d, Clock, Rst, 2'd0)
  // Shift register needs no reset: three fresh bytes always precede every use.
  `RVC_EN_MSFF(sh_q, sh_d, Clock, InValid)

  assign WordValid = InValid && (idx_q == 2'd3) && !Clr;
  assign Word      = {InData, sh_q};

endmodule

// File: rtl/rvc_asap_imem_loader.sv
// I_MEM boot loader: length-prefixed byte stream -> 32-bit I_MEM writes, holds the core
// in reset until the image is in place.
// Optional feature macro: RVC_LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte.

module rvc_asap_imem_loader
  import rvc_asap_pkg::*;
(
  input  logic        Clock,
  input  logic        Rst,
  input  logic        RxValid,
  input  logic [7:0]  RxData,
  output logic        RxReady,
  input  logic        LoadReq,
  output logic        IMemWrEn,
  output logic [31:0] IMemWrAddr,
  output logic [31:0] IMemWrData,
  output logic        CoreRst,
  output logic        LoadDone,
  output logic [1:0]  LoadErr
);

`ifdef RVC_LOADER_CHECKSUM_EN
  localparam t_loader_state S_AFTER_DATA = S_CSUM;
`else
  localparam t_loader_state S_AFTER_DATA = S_DONE;
`endif

  t_loader_state state_q, state_d;
  t_loader_err   err_q, err_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   len_full;
  logic          rx_fire, restart, done_d;
  logic          pack_valid;
  logic [31:0]   pack_word;
  logic          wr_en_d;
  logic [31:0]   wr_addr_d, wr_data_d;
`ifdef RVC_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d, csum_total;
`endif

  assign RxReady  = !Rst && (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM);
  assign rx_fire  = RxValid && RxReady;
  assign restart  = LoadReq && (state_q == S_DONE || state_q == S_ERR);
  assign len_full = {RxData, len_q[31:8]};
`ifdef RVC_LOADER_CHECKSUM_EN
  assign csum_total = sum_q + RxData;
`endif

  rvc_asap_byte_packer u_packer (
    .Clock     (Clock),
    .Rst       (Rst),
    .Clr       (restart),
    .InValid   (rx_fire && state_q == S_DATA),
    .InData    (RxData),
    .WordValid (pack_valid),
    .Word      (pack_word)
  );

  // Frame FSM: length capture, payload counting, checksum check and restart.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef RVC_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_LEN: begin
        if (rx_fire) begin
          len_d = len_full;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'd3) begin
            cnt_d = 32'd0;
            if (len_full[1:0] != 2'b00 || len_full > 32'(I_MEM_SIZE)) begin
              state_d = S_ERR;
              err_d   = ERR_LEN;
            end else if (len_full == 32'd0) begin
              state_d = S_AFTER_DATA;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          cnt_d = cnt_q + 32'd1;
`ifdef RVC_LOADER_CHECKSUM_EN
          sum_d = sum_q + RxData;
`endif
          if (cnt_q == len_q - 32'd1) state_d = S_AFTER_DATA;
        end
      end
`ifdef RVC_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_fire) begin
          if (csum_total == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_LEN;
          err_d   = ERR_NONE;
          len_d   = 32'd0;
          cnt_d   = 32'd0;
`ifdef RVC_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      default: state_d = S_LEN;
    endcase
  end

  // Write port next-state: strobe one cycle after the 4th byte; addr is the word's base.
  always_comb begin
    wr_en_d   = pack_valid;
    wr_addr_d = pack_valid ? {cnt_q[31:2], 2'b00} : IMemWrAddr;
    wr_data_d = pack_valid ? pack_word : IMemWrData;
  end

  // Release only from a settled S_DONE so the final write always lands first.
  assign done_d = (state_q == S_DONE) && !LoadReq;

  // FSM state and error code.
  `RVC_RST_MSFF(state_q, state_d, Clock, Rst, S_LEN)
  // Error code register.
  `RVC_RST_MSFF(err_q, err_d, Clock, Rst, ERR_NONE)
  // Length shift register.
  `RVC_RST_MSFF(len_q, len_d, Clock, Rst, 32'd0)
  // Byte counter (length bytes, then payload bytes).
  `RVC_RST_MSFF(cnt_q, cnt_d, Clock, Rst, 32'd0)
`ifdef RVC_LOADER_CHECKSUM_EN
  // Running payload sum.
  `RVC_RST_MSFF(sum_q, sum_d, Clock, Rst, 8'd0)
`endif
  // I_MEM write strobe.
  `RVC_RST_MSFF(IMemWrEn, wr_en_d, Clock, Rst, 1'b0)
  // I_MEM write address.
  `RVC_RST_MSFF(IMemWrAddr, wr_addr_d, Clock, Rst, 32'd0)
  // I_MEM write data.
  `RVC_RST_MSFF(IMemWrData, wr_data_d, Clock, Rst, 32'd0)
  // Core reset, released once the load is complete.
  `RVC_RST_MSFF(CoreRst, !done_d, Clock, Rst, 1'b1)
  // Load-done level.
  `RVC_RST_MSFF(LoadDone, done_d, Clock, Rst, 1'b0)

  assign LoadErr = err_q;

endmodule

// File: tb/tb_rvc_asap_imem_loader.sv
// Directed bench for rvc_asap_imem_loader; follows RVC_LOADER_CHECKSUM_EN if defined.

module tb_rvc_asap_imem_loader;

  logic        Clock = 1'b0;
  logic        Rst, RxValid, LoadReq;
  logic [7:0]  RxData;
  logic        RxReady, IMemWrEn, CoreRst, LoadDone;
  logic [31:0] IMemWrAddr, IMemWrData;
  logic [1:0]  LoadErr;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rel_writes = -1;
  logic        core_rst_prev = 1'b1;

  logic [7:0] t1_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  rvc_asap_imem_loader dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .RxValid    (RxValid),
    .RxData     (RxData),
    .RxReady    (RxReady),
    .LoadReq    (LoadReq),
    .IMemWrEn   (IMemWrEn),
    .IMemWrAddr (IMemWrAddr),
    .IMemWrData (IMemWrData),
    .CoreRst    (CoreRst),
    .LoadDone   (LoadDone),
    .LoadErr    (LoadErr)
  );

  always #5 Clock = ~Clock;

  // Capture writes and how many had happened when CoreRst fell.
  always @(negedge Clock) begin
    if (!Rst && IMemWrEn) begin
      wr_addr_q.push_back(IMemWrAddr);
      wr_data_q.push_back(IMemWrData);
    end
    if (core_rst_prev && !CoreRst) rel_writes = wr_addr_q.size();
    core_rst_prev = CoreRst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int kind, input int i);
    case (kind)
      0:       return t1_bytes[i];
      1:       return 8'(i);
      2:       return 8'(i * 7 + 3);
      default: return 8'(i + 1);
    endcase
  endfunction

  function automatic logic [7:0] good_csum(input int kind, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(pay(kind, i));
    return 8'((256 - (s & 255)) & 255);
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rel_writes = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RxValid = 1'b1;
    RxData  = b;
    @(negedge Clock);
    while (!RxReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!RxReady) check("rx_ready_timeout", 32'(RxReady), 32'd1);
    @(posedge Clock);
    #1;
    RxValid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge Clock);
    #1;
  endtask

  task automatic pulse_req();
    LoadReq = 1'b1;
    @(posedge Clock);
    #1;
    LoadReq = 1'b0;
  endtask

  // Full frame; csum < 0 selects the correct checksum. req_at >= 0 pulses LoadReq mid-load.
  task automatic send_frame(input int n, input int kind, input bit gaps, input int csum,
                            input int req_at);
    logic [31:0] len = 32'(n);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    for (int i = 0; i < n; i++) begin
      if (i == req_at) pulse_req();
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
      send_byte(pay(kind, i));
    end
`ifdef RVC_LOADER_CHECKSUM_EN
    send_byte(csum < 0 ? good_csum(kind, n) : 8'(csum));
`endif
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  task automatic check_t1_load(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_a0"}, wr_addr_q[0], 32'h0);
      check({tag, "_d0"}, wr_data_q[0], 32'h0000_0013);
      check({tag, "_a1"}, wr_addr_q[1], 32'h4);
      check({tag, "_d1"}, wr_data_q[1], 32'h0010_0093);
    end
    check({tag, "_done"}, 32'(LoadDone), 32'd1);
    check({tag, "_corerst"}, 32'(CoreRst), 32'd0);
    check({tag, "_err"}, 32'(LoadErr), 32'd0);
    check({tag, "_rel_after_wr"}, 32'(rel_writes), 32'd2);
    check({tag, "_rxready"}, 32'(RxReady), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; RxValid = 1'b0; RxData = 8'h00; LoadReq = 1'b0;
    idle(3);
    check("rst_wren", 32'(IMemWrEn), 32'd0);
    check("rst_addr", IMemWrAddr, 32'd0);
    check("rst_data", IMemWrData, 32'd0);
    check("rst_corerst", 32'(CoreRst), 32'd1);
    check("rst_done", 32'(LoadDone), 32'd0);
    check("rst_err", 32'(LoadErr), 32'd0);
    check("rst_rxready", 32'(RxReady), 32'd0);
    Rst = 1'b0;
    idle(1);
    check("idle_rxready", 32'(RxReady), 32'd1);

    // 1: two-word image
    clear_log();
    send_frame(8, 0, 1'b0, -1, -1);
    idle(3);
    check_t1_load("t1");

    // 2: length not a multiple of 4
    pulse_req();
    check("t2_req_corerst", 32'(CoreRst), 32'd1);
    check("t2_req_done", 32'(LoadDone), 32'd0);
    clear_log();
    send_len(32'd6);
    idle(1);
    check("t2_err", 32'(LoadErr), 32'd1);
    check("t2_rxready", 32'(RxReady), 32'd0);
    idle(2);
    check("t2_corerst", 32'(CoreRst), 32'd1);
    check("t2_nwr", 32'(wr_addr_q.size()), 32'd0);

    // 3: oversize, empty and exactly-full images
    pulse_req();
    check("t3_req_err", 32'(LoadErr), 32'd0);
    send_len(32'h1004);
    idle(1);
    check("t3_big_err", 32'(LoadErr), 32'd1);
    pulse_req();
    clear_log();
    send_frame(0, 1, 1'b0, -1, -1);
    idle(3);
    check("t3_zero_done", 32'(LoadDone), 32'd1);
    check("t3_zero_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("t3_zero_err", 32'(LoadErr), 32'd0);
    pulse_req();
    clear_log();
    send_frame(4096, 1, 1'b0, -1, -1);
    idle(3);
    check("t3_full_nwr", 32'(wr_addr_q.size()), 32'd1024);
    if (wr_addr_q.size() == 1024) begin
      check("t3_full_lasta", wr_addr_q[1023], 32'hFFC);
      check("t3_full_lastd", wr_data_q[1023], 32'hFFFE_FDFC);
    end
    check("t3_full_done", 32'(LoadDone), 32'd1);

`ifdef RVC_LOADER_CHECKSUM_EN
    // 4: bad checksum, then recovery
    pulse_req();
    clear_log();
    send_frame(4, 3, 1'b0, 0, -1);
    idle(3);
    check("t4_bad_err", 32'(LoadErr), 32'd2);
    check("t4_bad_corerst", 32'(CoreRst), 32'd1);
    check("t4_bad_done", 32'(LoadDone), 32'd0);
    pulse_req();
    clear_log();
    send_frame(4, 3, 1'b0, 'hF6, -1);
    idle(3);
    check("t4_good_done", 32'(LoadDone), 32'd1);
    check("t4_good_err", 32'(LoadErr), 32'd0);
    check("t4_good_d0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h0403_0201);
`endif

    // 5: random gaps, LoadReq mid-load ignored
    pulse_req();
    clear_log();
    send_frame(64, 2, 1'b1, -1, 20);
    idle(3);
    check("t5_nwr", 32'(wr_addr_q.size()), 32'd16);
    for (int w = 0; w < 16 && w < wr_addr_q.size(); w++) begin
      check($sformatf("t5_a%0d", w), wr_addr_q[w], 32'(4 * w));
      check($sformatf("t5_d%0d", w), wr_data_q[w],
            {pay(2, 4*w+3), pay(2, 4*w+2), pay(2, 4*w+1), pay(2, 4*w)});
    end
    check("t5_done", 32'(LoadDone), 32'd1);
    check("t5_rel", 32'(rel_writes), 32'd16);

    // 6: async reset mid-load, then a clean reload
    pulse_req();
    clear_log();
    send_len(32'd8);
    send_byte(8'h13);
    send_byte(8'h00);
    Rst = 1'b1;
    #1;
    check("t6_wren", 32'(IMemWrEn), 32'd0);
    check("t6_addr", IMemWrAddr, 32'd0);
    check("t6_data", IMemWrData, 32'd0);
    check("t6_corerst", 32'(CoreRst), 32'd1);
    check("t6_done", 32'(LoadDone), 32'd0);
    check("t6_err", 32'(LoadErr), 32'd0);
    check("t6_rxready", 32'(RxReady), 32'd0);
    idle(2);
    Rst = 1'b0;
    idle(1);
    clear_log();
    send_frame(8, 0, 1'b0, -1, -1);
    idle(3);
    check_t1_load("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
